ibus_prefetcher: RTL and testbench

IBUS_PREFETCHER -- requirements
Module: ibus_prefetcher

---
 rtl/ibus_prefetcher.sv | 185 ++++++++++++++++++
 tb/tb_ibus_prefetcher.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_prefetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ibus_prefetcher                                               |
// | Purpose  : Instruction prefetcher. Issues 4-byte read requests on the    |
// |            instruction bus with at most one outstanding, buffers the     |
// |            returned words in a DEPTH-entry FIFO and presents them to the |
// |            core on a valid/ready stream. A redirect flushes the FIFO and |
// |            restarts fetch, and a bus fault halts fetch until the next    |
// |            redirect.                                                     |
// | Ports    : clk, rstn (async, active low)                                 |
// |            redirect, redirect_pc       - flush and restart fetch         |
// |            i_addr/i_w_rb/i_acc/i_wdata/i_req - bus request (read only)   |
// |            i_rdata/i_resp/i_fault      - bus response                    |
// |            out_valid/out_ready/out_instr/out_pc/out_fault - core stream  |
// | Options  : IPREFETCH_BYPASS_EN - when defined, a response that arrives   |
// |            with the FIFO empty is presented to the core in the same      |
// |            cycle and is not buffered if the core takes it at once.       |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module ibus_prefetcher #(
    parameter int                DEPTH    = 2,
    parameter logic [`XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic                            redirect,
    input  logic [`XLEN-1:0]                redirect_pc,
    output logic [`XLEN-1:0]                i_addr,
    output logic                            i_w_rb,
    output logic [$clog2(`BUS_ACC_CNT)-1:0] i_acc,
    output logic [`BUS_WIDTH-1:0]           i_wdata,
    output logic                            i_req,
    input  logic [`BUS_WIDTH-1:0]           i_rdata,
    input  logic                            i_resp,
    input  logic                            i_fault,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [31:0]                     out_instr,
    output logic [`XLEN-1:0]                out_pc,
    output logic                            out_fault
);

    localparam int c_XLEN  = `XLEN;
    localparam int c_ACC_W = $clog2(`BUS_ACC_CNT);
    localparam int c_PW    = $clog2(DEPTH);
    localparam int c_CW    = $clog2(DEPTH) + 1;

    localparam logic [c_ACC_W-1:0] c_ACC_WORD = c_ACC_W'(2);
    localparam logic [c_XLEN-1:0]  c_PC_STEP  = c_XLEN'(4);
    localparam logic [c_CW-1:0]    c_FULL     = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]    c_CNT_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0]    c_PTR_ONE  = c_PW'(1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_WAIT    = 2'd1;
    localparam logic [1:0] c_DISCARD = 2'd2;
    localparam logic [1:0] c_HALT    = 2'd3;

    logic [1:0]        r_state;
    logic [c_XLEN-1:0] r_fetch_pc;
    logic              r_req;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_CW-1:0]   r_count;
    logic [31:0]       r_instr [DEPTH];
    logic [c_XLEN-1:0] r_pc    [DEPTH];
    logic              r_fault [DEPTH];

    logic w_resp_ok;
    logic w_owed;
    logic w_push;
    logic w_pop;

    // Low address bits of the redirect target are forced to zero.
    wire w_unused = &{1'b0, redirect_pc[1:0]};

    assign i_addr  = r_fetch_pc;
    assign i_w_rb  = 1'b0;
    assign i_acc   = c_ACC_WORD;
    assign i_wdata = '0;
    assign i_req   = r_req;

    // A response is only kept when it belongs to the live request; a
    // same-cycle redirect makes it stale.
    assign w_resp_ok = (r_state == c_WAIT) && i_resp && !redirect;
    assign w_owed    = (r_state == c_WAIT) || (r_state == c_DISCARD);
    assign w_pop     = (r_count != '0) && out_ready && !redirect;

`ifdef IPREFETCH_BYPASS_EN
    logic w_bypass;
    assign w_bypass  = w_resp_ok && (r_count == '0);
    assign out_valid = (r_count != '0) || w_bypass;
    assign out_instr = w_bypass ? i_rdata[31:0] : r_instr[r_rd_ptr];
    assign out_pc    = w_bypass ? r_fetch_pc    : r_pc[r_rd_ptr];
    assign out_fault = w_bypass ? i_fault       : r_fault[r_rd_ptr];
    // A bypassed word taken by the core in the same cycle is never stored.
    assign w_push    = w_resp_ok && !(w_bypass && out_ready);
`else
    assign out_valid = (r_count != '0);
    assign out_instr = r_instr[r_rd_ptr];
    assign out_pc    = r_pc[r_rd_ptr];
    assign out_fault = r_fault[r_rd_ptr];
    assign w_push    = w_resp_ok;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= c_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req      <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= '0;
                r_pc[i]    <= '0;
                r_fault[i] <= 1'b0;
            end
        end else begin
            r_req <= 1'b0;
            if (redirect) begin
                // Flush wins over any pop or push this cycle. If the bus
                // still owes a response it must be swallowed in DISCARD.
                r_fetch_pc <= {redirect_pc[c_XLEN-1:2], 2'b00};
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                r_state    <= (w_owed && !i_resp) ? c_DISCARD : c_IDLE;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        // Gating on free space is what makes overflow impossible.
                        if (r_count < c_FULL) begin
                            r_req   <= 1'b1;
                            r_state <= c_WAIT;
                        end
                    end
                    c_WAIT: begin
                        if (i_resp) begin
                            r_fetch_pc <= r_fetch_pc + c_PC_STEP;
                            r_state    <= i_fault ? c_HALT : c_IDLE;
                        end
                    end
                    c_DISCARD: begin
                        if (i_resp) begin
                            r_state <= c_IDLE;
                        end
                    end
                    c_HALT: begin
                        r_state <= c_HALT;
                    end
                    default: r_state <= c_IDLE;
                endcase

                if (w_push) begin
                    r_instr[r_wr_ptr] <= i_rdata[31:0];
                    r_pc[r_wr_ptr]    <= r_fetch_pc;
                    r_fault[r_wr_ptr] <= i_fault;
                    r_wr_ptr          <= r_wr_ptr + c_PTR_ONE;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + c_CNT_ONE;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - c_CNT_ONE;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ibus_prefetcher.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ibus_prefetcher                                            |
// | Purpose  : Directed self-checking bench for ibus_prefetcher. A small bus |
// |            slave answers each request after a programmable latency with |
// |            data {16'hC0DE, addr[15:0]}; a monitor logs every word the   |
// |            core accepts. Covers the IPREFETCH_BYPASS_EN build as well.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+

`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 4
`endif

module tb_ibus_prefetcher;

    logic                            clk = 1'b0;
    logic                            rstn;
    logic                            redirect;
    logic [`XLEN-1:0]                redirect_pc;
    logic [`XLEN-1:0]                i_addr;
    logic                            i_w_rb;
    logic [$clog2(`BUS_ACC_CNT)-1:0] i_acc;
    logic [`BUS_WIDTH-1:0]           i_wdata;
    logic                            i_req;
    logic [`BUS_WIDTH-1:0]           i_rdata;
    logic                            i_resp;
    logic                            i_fault;
    logic                            out_valid;
    logic                            out_ready;
    logic [31:0]                     out_instr;
    logic [`XLEN-1:0]                out_pc;
    logic                            out_fault;

    int n_tests = 0;
    int n_fail  = 0;

    // Bus slave state
    int          lat        = 1;
    bit          pend       = 1'b0;
    int          cnt        = 0;
    logic [31:0] pend_addr  = '0;
    bit          fault_en   = 1'b0;
    logic [31:0] fault_addr = '0;

    logic [31:0] req_log[$];
    logic [31:0] pop_pc_q[$];
    logic [31:0] pop_instr_q[$];
    logic        pop_fault_q[$];

    always #5 clk = ~clk;

    ibus_prefetcher #(
        .DEPTH    (2),
        .RESET_PC (32'h0000_0000)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .i_addr      (i_addr),
        .i_w_rb      (i_w_rb),
        .i_acc       (i_acc),
        .i_wdata     (i_wdata),
        .i_req       (i_req),
        .i_rdata     (i_rdata),
        .i_resp      (i_resp),
        .i_fault     (i_fault),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_fault   (out_fault)
    );

    // Slave: a request seen in cycle N is answered in cycle N+lat.
    always @(negedge clk) begin
        i_resp  = 1'b0;
        i_fault = 1'b0;
        if (pend) begin
            if (cnt == 0) begin
                i_resp  = 1'b1;
                i_rdata = {16'hC0DE, pend_addr[15:0]};
                i_fault = fault_en && (pend_addr == fault_addr);
                pend    = 1'b0;
            end else begin
                cnt = cnt - 1;
            end
        end
        if (i_req === 1'b1 && rstn === 1'b1) begin
            pend      = 1'b1;
            cnt       = lat - 1;
            pend_addr = i_addr;
            req_log.push_back(i_addr);
        end
    end

    // Monitor of words accepted by the core.
    always @(negedge clk) begin
        #1;
        if (rstn === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1 && redirect === 1'b0) begin
            pop_pc_q.push_back(out_pc);
            pop_instr_q.push_back(out_instr);
            pop_fault_q.push_back(out_fault);
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic rdy, input int l);
        @(negedge clk);
        rstn      = 1'b0;
        redirect  = 1'b0;
        out_ready = rdy;
        lat       = l;
        fault_en  = 1'b0;
        pend      = 1'b0;
        repeat (2) @(negedge clk);
        pend = 1'b0;
        req_log.delete();
        pop_pc_q.delete();
        pop_instr_q.delete();
        pop_fault_q.delete();
        rstn = 1'b1;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (i_req !== 1'b1 && k < budget);
        check_value(tag, {31'd0, i_req}, 32'd1);
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int k = 0;
        while (pop_pc_q.size() < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #2;
        check_value(tag, {31'd0, pop_pc_q.size() >= n}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn        = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        out_ready   = 1'b1;
        i_resp      = 1'b0;
        i_rdata     = '0;
        i_fault     = 1'b0;

        // Reset state and constant bus attributes
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_req",   {31'd0, i_req},     32'd0);
        check_value("rst_valid", {31'd0, out_valid}, 32'd0);
        check_value("rst_instr", out_instr,          32'd0);
        check_value("rst_pc",    out_pc,             32'd0);
        check_value("rst_fault", {31'd0, out_fault}, 32'd0);
        check_value("rst_w_rb",  {31'd0, i_w_rb},    32'd0);
        check_value("rst_acc",   {30'd0, i_acc},     32'd2);
        check_value("rst_wdata", i_wdata,            32'd0);

        // First request right after reset release, then sequential fetch
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        #1;
        check_value("first_req",  {31'd0, i_req}, 32'd1);
        check_value("first_addr", i_addr,         32'h0);
        wait_pops("seq_pops", 3, 60);
        check_value("seq_addr0", req_log[0], 32'h0);
        check_value("seq_addr1", req_log[1], 32'h4);
        check_value("seq_addr2", req_log[2], 32'h8);
        check_value("seq_pc0",   pop_pc_q[0], 32'h0);
        check_value("seq_pc1",   pop_pc_q[1], 32'h4);
        check_value("seq_pc2",   pop_pc_q[2], 32'h8);
        check_value("seq_data1", pop_instr_q[1], 32'hC0DE_0004);
        check_value("seq_flt0",  {31'd0, pop_fault_q[0]}, 32'd0);

        // Backpressure: FIFO of 2 fills, fetch stops, then resumes at 0x8
        do_reset(1'b0, 1);
        repeat (20) @(negedge clk);
        #1;
        check_value("full_nreq",  req_log.size(),        32'd2);
        check_value("full_req",   {31'd0, i_req},        32'd0);
        check_value("full_valid", {31'd0, out_valid},    32'd1);
        check_value("full_pc",    out_pc,                32'h0);
        check_value("full_instr", out_instr,             32'hC0DE_0000);
        @(negedge clk);
        #1;
        check_value("hold_instr", out_instr, 32'hC0DE_0000);
        check_value("hold_pc",    out_pc,    32'h0);
        @(negedge clk);
        out_ready = 1'b1;
        wait_pops("full_pops", 3, 40);
        check_value("resume_addr", req_log[2],  32'h8);
        check_value("resume_pc0",  pop_pc_q[0], 32'h0);
        check_value("resume_pc2",  pop_pc_q[2], 32'h8);

        // Redirect in WAIT; stale response three cycles later is dropped
        do_reset(1'b1, 4);
        wait_req("rdw_req", 20);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        lat         = 1;
        @(negedge clk);
        redirect = 1'b0;
        wait_pops("rdw_pops", 1, 40);
        check_value("rdw_nreq",  {31'd0, req_log.size() >= 2}, 32'd1);
        check_value("rdw_addr",  req_log[1],     32'h100);
        check_value("rdw_pc",    pop_pc_q[0],    32'h100);
        check_value("rdw_instr", pop_instr_q[0], 32'hC0DE_0100);

        // Fault at 0x4 halts fetch until a redirect to 0x40
        do_reset(1'b1, 1);
        fault_en   = 1'b1;
        fault_addr = 32'h4;
        repeat (20) @(negedge clk);
        #1;
        check_value("flt_nreq", req_log.size(),  32'd2);
        check_value("flt_req",  {31'd0, i_req},  32'd0);
        check_value("flt_npop", pop_pc_q.size(), 32'd2);
        check_value("flt_pc",   pop_pc_q[1],     32'h4);
        check_value("flt_bit1", {31'd0, pop_fault_q[1]}, 32'd1);
        check_value("flt_bit0", {31'd0, pop_fault_q[0]}, 32'd0);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        fault_en    = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
        wait_pops("flt_pops", 3, 40);
        check_value("flt_raddr", req_log[2],     32'h40);
        check_value("flt_rpc",   pop_pc_q[2],    32'h40);
        check_value("flt_rbit",  {31'd0, pop_fault_q[2]}, 32'd0);

        // Redirect coinciding with the response: no push, refetch at target
        do_reset(1'b1, 1);
        wait_req("rsr_req", 20);
        @(negedge clk);
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        redirect = 1'b0;
        #1;
        check_value("rsr_nopush", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check_value("rsr_req2", {31'd0, i_req}, 32'd1);
        check_value("rsr_addr", i_addr,         32'h200);
        wait_pops("rsr_pops", 1, 30);
        check_value("rsr_pc", pop_pc_q[0], 32'h200);

        // Response-to-output latency with an empty FIFO
        do_reset(1'b1, 1);
        wait_req("lat_req", 20);
        @(negedge clk);
        #1;
`ifdef IPREFETCH_BYPASS_EN
        check_value("byp_valid", {31'd0, out_valid}, 32'd1);
        check_value("byp_instr", out_instr,          32'hC0DE_0000);
        check_value("byp_pc",    out_pc,             32'h0);
        @(negedge clk);
        #1;
        check_value("byp_empty", {31'd0, out_valid}, 32'd0);
`else
        check_value("lat_comb",  {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        #1;
        check_value("lat_valid", {31'd0, out_valid}, 32'd1);
        check_value("lat_pc",    out_pc,             32'h0);
        check_value("lat_instr", out_instr,          32'hC0DE_0000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
